// File: rtl/priority_encoder_42_seq.sv
// Sequential priority encoder: sticky pending requests granted one index at a time over valid/ready.
// Define PRIO_ROUND_ROBIN_EN for rotating priority; default build uses fixed highest-index priority.
module priority_encoder_42_seq #(
  parameter int WIDTH  = 4,
  parameter int CODE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  req,
  input  logic              flush,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic [WIDTH-1:0]  pending,
  output logic              busy
);

  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic [WIDTH-1:0]  pending_q;

  logic [WIDTH-1:0]  cand;
  logic              slot_free;
  logic [CODE_W-1:0] winner;

  logic [CODE_W-1:0] code_d;
  logic              valid_d;
  logic [WIDTH-1:0]  pending_d;

  assign cand      = pending_q | req;
  assign slot_free = !valid_q || ready;

`ifdef PRIO_ROUND_ROBIN_EN
  logic [CODE_W-1:0] ptr_q;
  logic [CODE_W-1:0] ptr_d;

  // Scan from the far end of the search order so the first hit from (ptr-1) downward wins.
  always_comb begin
    logic [CODE_W-1:0] idx;
    winner = '0;
    for (int k = WIDTH; k >= 1; k--) begin
      idx = ptr_q - CODE_W'(k);
      if (cand[idx]) winner = idx;
    end
  end
`else
  // Ascending scan: the highest set index is the last assignment and wins.
  always_comb begin
    winner = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cand[i]) winner = CODE_W'(i);
    end
  end
`endif

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    code_d    = code_q;
    valid_d   = valid_q;
    pending_d = cand;
`ifdef PRIO_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    if (flush) begin
      valid_d   = 1'b0;
      pending_d = '0;
`ifdef PRIO_ROUND_ROBIN_EN
      ptr_d     = CODE_W'(WIDTH - 1);
`endif
    end else if (slot_free) begin
      if (cand != '0) begin
        code_d    = winner;
        valid_d   = 1'b1;
        pending_d = cand & ~(WIDTH'(1) << winner);
`ifdef PRIO_ROUND_ROBIN_EN
        ptr_d     = winner;
`endif
      end else begin
        valid_d   = 1'b0;
        pending_d = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_q    <= '0;
      valid_q   <= 1'b0;
      pending_q <= '0;
`ifdef PRIO_ROUND_ROBIN_EN
      ptr_q     <= CODE_W'(WIDTH - 1);
`endif
    end else begin
      code_q    <= code_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
`ifdef PRIO_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign busy    = valid_q || (pending_q != '0);

endmodule

// File: tb/tb_priority_encoder_42_seq.sv
// Self-checking bench for priority_encoder_42_seq: reference model feeds a scoreboard queue
// of expected post-edge outputs; honours PRIO_ROUND_ROBIN_EN like the design.
module tb_priority_encoder_42_seq;

  localparam int WIDTH  = 4;
  localparam int CODE_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WIDTH-1:0]  req;
  logic              flush;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic              ready;
  logic [WIDTH-1:0]  pending;
  logic              busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              valid;
    logic [WIDTH-1:0]  pending;
    logic              busy;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [CODE_W-1:0] m_code  = '0;
  logic              m_valid = 1'b0;
  logic [WIDTH-1:0]  m_pend  = '0;
  int                m_ptr   = WIDTH - 1;

  priority_encoder_42_seq #(.WIDTH(WIDTH), .CODE_W(CODE_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .flush   (flush),
    .code    (code),
    .valid   (valid),
    .ready   (ready),
    .pending (pending),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [WIDTH-1:0] c, input int ptr);
`ifdef PRIO_ROUND_ROBIN_EN
    for (int k = 1; k <= WIDTH; k++) begin
      int idx = (ptr + WIDTH - k) % WIDTH;
      if (c[idx]) return idx;
    end
    return 0;
`else
    for (int i = WIDTH - 1; i >= 0; i--) if (c[i]) return i;
    return 0;
`endif
  endfunction

  // Drive one cycle of stimulus, advance the model, then compare after the edge.
  task automatic cycle(input logic [WIDTH-1:0] r, input logic rd, input logic fl, input logic rs);
    logic [WIDTH-1:0] cand;
    exp_t e, got;
    int w;
    req = r; ready = rd; flush = fl; rst_n = rs;
    if (!rs) begin
      m_code = '0; m_valid = 1'b0; m_pend = '0; m_ptr = WIDTH - 1;
    end else if (fl) begin
      m_valid = 1'b0; m_pend = '0; m_ptr = WIDTH - 1;
    end else begin
      cand = m_pend | r;
      if (!m_valid || rd) begin
        if (cand != 0) begin
          w = pick(cand, m_ptr);
          m_code  = CODE_W'(w);
          m_valid = 1'b1;
          m_pend  = cand;
          m_pend[w] = 1'b0;
          m_ptr   = w;
        end else begin
          m_valid = 1'b0;
          m_pend  = '0;
        end
      end else begin
        m_pend = cand;
      end
    end
    e.code = m_code; e.valid = m_valid; e.pending = m_pend;
    e.busy = m_valid || (m_pend != 0);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("code",    32'(code),    32'(got.code));
    check("valid",   32'(valid),   32'(got.valid));
    check("pending", 32'(pending), 32'(got.pending));
    check("busy",    32'(busy),    32'(got.busy));
  endtask

  initial begin
    req = '0; ready = 1'b0; flush = 1'b0; rst_n = 1'b0;
    @(negedge clk);

    // Reset held two cycles with all requests asserted
    cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    check("post_rst_idle", 32'(valid), 32'd0);

    // Single request
    cycle(4'b0100, 1'b1, 1'b0, 1'b1);
    check("single_code", 32'(code), 32'd2);
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    check("single_drop", 32'(valid), 32'd0);

    // Multi-hot burst
    cycle(4'b1011, 1'b1, 1'b0, 1'b1);
`ifndef PRIO_ROUND_ROBIN_EN
    check("burst_first", 32'(code), 32'd3);
`endif
    repeat (3) cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    check("burst_idle", 32'(busy), 32'd0);

    // Backpressure
    cycle(4'b0011, 1'b0, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b0, 1'b1);
`ifndef PRIO_ROUND_ROBIN_EN
    check("bp_code", 32'(code),    32'd1);
    check("bp_pend", 32'(pending), 32'd1);
`endif
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);

    // Merge on the held index yields a second grant
    cycle(4'b1000, 1'b0, 1'b0, 1'b1);
    cycle(4'b1000, 1'b0, 1'b0, 1'b1);
    check("merge_pend", 32'(pending), 32'h8);
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    check("merge_regrant", 32'(code), 32'd3);
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);

    // Flush discards same-cycle request
    cycle(4'b1000, 1'b0, 1'b0, 1'b1);
    cycle(4'b1000, 1'b0, 1'b0, 1'b1);
    cycle(4'b0100, 1'b0, 1'b1, 1'b1);
    check("flush_valid", 32'(valid),   32'd0);
    check("flush_pend",  32'(pending), 32'd0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);

    // Mid-operation reset
    cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    check("midrst_idle", 32'(busy), 32'd0);

    // Saturating requests after reset (rotating sequence when round-robin is enabled)
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (12) cycle(4'b1111, 1'b1, 1'b0, 1'b1);

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      cycle(WIDTH'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 49) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/priority_encoder_42_seq.md
Name: priority_encoder_42_seq

Overview:
- Sequential priority encoder: the encoding counterpart of the 2-to-4 priority decoder.
- Captures one-hot or multi-hot request pulses into a sticky pending register.
- Emits the binary index of the winning request, one at a time, over a valid/ready handshake.
- Sits in front of the 2-to-4 decoder so that `code` can drive the decoder's `a`/`b` inputs directly.

Parameters:
- WIDTH, 4, number of request lines; must be a power of two, at least 2.
- CODE_W, 2, code width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active low.
- req  input  WIDTH  request pulses; bit i set requests index i; sampled every rising edge.
- flush  input  1  synchronous clear of all pending requests and the output slot.
- code  output  CODE_W  binary index of the granted request.
- valid  output  1  code is held and valid.
- ready  input  1  consumer accepts code this cycle when valid=1.
- pending  output  WIDTH  requests captured but not yet granted.
- busy  output  1  valid OR (pending != 0).

Behaviour:
- Reset: rst_n=0 sampled at a rising edge forces the following, regardless of all other inputs:
  - code=0, valid=0, pending=0, busy=0.
  - Round-robin pointer (optional feature) = WIDTH-1.
- Definitions:
  - cand = pending | req.
  - slot_free = (valid==0) OR (valid==1 AND ready==1).
- Fixed priority: winner is the highest set index of cand (bit WIDTH-1 has top priority).
- Per rising edge, with rst_n=1 and flush=0:
  - If slot_free and cand != 0:
    - code <= winner, valid <= 1.
    - pending <= cand with the winner bit cleared.
  - If slot_free and cand == 0:
    - valid <= 0, code holds its last value, pending <= 0.
  - If slot not free (valid=1, ready=0):
    - code and valid hold.
    - pending <= cand.
- Latency: a req bit seen at edge n with the slot free produces valid=1 and code=index after edge n (one cycle).
- Back-to-back: with ready held high and k pending bits, valid stays 1 for k consecutive cycles with a new code each cycle. No bubble between grants.
- Merging:
  - A req on a bit that is already pending merges into the existing request (single grant).
  - A req on the bit being granted in the same cycle merges into that grant.
  - A req on the index currently held on code (valid=1, not yet accepted) sets pending for that bit. This yields a second grant later.
- flush=1 (with rst_n=1): valid <= 0 and pending <= 0; req in the same cycle is discarded; code holds. Reset has priority over flush.
- Handshake rules:
  - Once valid=1, code must not change until the cycle in which ready=1.
  - ready while valid=0 has no effect.
- Output signals:
  - busy is combinational from the registered valid and pending.
  - pending is the registered value.
- Mid-operation reset clears held codes and all pending requests. No grant is issued for requests sampled in the reset cycle.

Optional Feature:
- Macro: PRIO_ROUND_ROBIN_EN.
- Defined:
  - Winner is the first set bit of cand searching downward from (ptr-1) mod WIDTH, wrapping around, and ending at ptr.
  - On each load, ptr <= winner.
  - Reset and flush set ptr = WIDTH-1, so the first search starts at index WIDTH-2 and bit WIDTH-1 has lowest priority after reset.
  - Guarantees every pending request is granted within WIDTH grants.
- Undefined: fixed highest-index priority as above; no pointer register is present.

Test Plan:
- Reset: hold rst_n=0 two cycles with req=4'b1111 -> code=0, valid=0, pending=0, busy=0. Release -> no grant until a new req.
- Single request: req=4'b0100 for one cycle, ready=1 -> next cycle valid=1, code=2'd2, pending=0. Following cycle valid=0.
- Multi-hot burst (fixed priority): req=4'b1011 for one cycle, ready=1 -> codes 3, 1, 0 on three consecutive cycles. valid falls in the fourth cycle; busy=0 after.
- Backpressure: req=4'b0011, ready=0 for 3 cycles -> code=1 held with valid=1 and pending=4'b0001. ready=1 -> code=0 next cycle.
- Merge and flush:
  - Hold code=3 valid with ready=0, then pulse req=4'b1000 -> pending=4'b1000.
  - Release ready -> second code=3.
  - Repeat the setup, then pulse flush -> valid=0, pending=0.
- Round-robin (PRIO_ROUND_ROBIN_EN defined): after reset, hold req=4'b1111 every cycle with ready=1 -> code sequence 2, 1, 0, 3, 2, 1, ...
